pc_npc_sequencer: RTL and testbench

- Controls the PC/NPC pair for the fetch stage of the pipelined CPU and owns the PC+4 increment.
- Sequences the fetch handshake to instruction memory and holds PC/NPC on hazard stalls.
- Applies delay-slot branch redirects (PC<=NPC, NPC<=target), with an optional annul of the delay-slot instruction.
- Sits between the hazard unit, the branch-resolution logic and instruction memory.

---
 rtl/pc_npc_sequencer.sv | 146 ++++++++++++++
 tb/tb_pc_npc_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_npc_sequencer.sv
// rtl/pc_npc_sequencer.sv - fetch-stage PC/NPC sequencer with imem handshake,
// hazard hold and delay-slot branch redirect with optional annul.
module pc_npc_sequencer #(
  parameter int unsigned          WIDTH    = 32,
  parameter logic [WIDTH-1:0]     RESET_PC = '0,
  parameter logic [WIDTH-1:0]     INC      = WIDTH'(4)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             stall_i,
  input  logic             branch_taken_i,
  input  logic             branch_annul_i,
  input  logic [WIDTH-1:0] branch_target_i,
  input  logic             fetch_ack_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] npc_o,
  output logic             fetch_req_o,
  output logic             fetch_valid_o,
  output logic             squash_o,
  output logic             branch_err_o,
  output logic [31:0]      fetch_count_o
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] npc_q, npc_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  logic             pend_annul_q, pend_annul_d;
  logic             annul_arm_q, annul_arm_d;
  logic             fetch_valid_q, fetch_valid_d;
  logic             squash_q, squash_d;
  logic             err_q, err_d;
  logic [31:0]      count_q, count_d;

  logic             fetch_req;
  logic             advance;
  logic             redirect;
  logic [WIDTH-1:0] redirect_tgt;
  logic             redirect_annul;

  always_comb begin
    state_d   = state_q;
    fetch_req = 1'b0;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        fetch_req = ~stall_i;
        if (stall_i)           state_d = ST_HOLD;
        else if (!fetch_ack_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // An outstanding request must complete even if a stall arrives.
        fetch_req = 1'b1;
        if (fetch_ack_i) state_d = stall_i ? ST_HOLD : ST_RUN;
      end
      ST_HOLD: begin
        if (!stall_i) state_d = ST_RUN;
      end
      default: state_d = ST_BOOT;
    endcase
  end

  assign advance        = fetch_req & fetch_ack_i;
  // A pending branch is older than any branch arriving now, so it wins.
  assign redirect       = pend_q | branch_taken_i;
  assign redirect_tgt   = pend_q ? pend_tgt_q   : branch_target_i;
  assign redirect_annul = pend_q ? pend_annul_q : branch_annul_i;

  always_comb begin
    pc_d          = pc_q;
    npc_d         = npc_q;
    pend_d        = pend_q;
    pend_tgt_d    = pend_tgt_q;
    pend_annul_d  = pend_annul_q;
    annul_arm_d   = annul_arm_q;
    err_d         = err_q;
    count_d       = count_q;
    fetch_valid_d = advance;
    squash_d      = advance & annul_arm_q;
    if (advance) begin
      pc_d        = npc_q;
      npc_d       = redirect ? redirect_tgt : npc_q + INC;
      annul_arm_d = redirect & redirect_annul;
      count_d     = count_q + 32'd1;
      // Consuming the pending branch frees the slot for a branch arriving now.
      pend_d      = pend_q & branch_taken_i;
      if (pend_q && branch_taken_i) begin
        pend_tgt_d   = branch_target_i;
        pend_annul_d = branch_annul_i;
      end
    end else if (branch_taken_i) begin
      if (pend_q) begin
        err_d = 1'b1;
      end else begin
        pend_d       = 1'b1;
        pend_tgt_d   = branch_target_i;
        pend_annul_d = branch_annul_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      npc_q         <= RESET_PC + INC;
      pend_q        <= 1'b0;
      pend_tgt_q    <= '0;
      pend_annul_q  <= 1'b0;
      annul_arm_q   <= 1'b0;
      fetch_valid_q <= 1'b0;
      squash_q      <= 1'b0;
      err_q         <= 1'b0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      npc_q         <= npc_d;
      pend_q        <= pend_d;
      pend_tgt_q    <= pend_tgt_d;
      pend_annul_q  <= pend_annul_d;
      annul_arm_q   <= annul_arm_d;
      fetch_valid_q <= fetch_valid_d;
      squash_q      <= squash_d;
      err_q         <= err_d;
      count_q       <= count_d;
    end
  end

  assign pc_o          = pc_q;
  assign npc_o         = npc_q;
  assign fetch_req_o   = fetch_req;
  assign fetch_valid_o = fetch_valid_q;
  assign squash_o      = squash_q;
  assign branch_err_o  = err_q;
  assign fetch_count_o = count_q;

endmodule

// File: tb/tb_pc_npc_sequencer.sv
// tb/tb_pc_npc_sequencer.sv - self-checking bench for pc_npc_sequencer using
// per-cycle expected snapshots queued as stimulus is applied.
module tb_pc_npc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic        branch_annul = 1'b0;
  logic [31:0] branch_target = '0;
  logic        fetch_ack = 1'b0;
  logic [31:0] pc, npc, fetch_count;
  logic        fetch_req, fetch_valid, squash, branch_err;

  int checks = 0;
  int passed = 0;

  typedef struct packed {
    logic        st, ack, br, an;
    logic [31:0] tgt, pc, npc;
    logic        req, vld, sq, err;
  } row_t;

  row_t sb[$];

  pc_npc_sequencer dut (
    .clk_i(clk), .reset_i(reset), .stall_i(stall),
    .branch_taken_i(branch_taken), .branch_annul_i(branch_annul),
    .branch_target_i(branch_target), .fetch_ack_i(fetch_ack),
    .pc_o(pc), .npc_o(npc), .fetch_req_o(fetch_req),
    .fetch_valid_o(fetch_valid), .squash_o(squash),
    .branch_err_o(branch_err), .fetch_count_o(fetch_count)
  );

  always #5 clk = ~clk;

  function automatic row_t mk(input logic st, ack, br, an, input logic [31:0] tgt,
                              input logic [31:0] epc, enpc, input logic req, vld, sq, err);
    row_t r;
    r.st = st; r.ack = ack; r.br = br; r.an = an; r.tgt = tgt;
    r.pc = epc; r.npc = enpc; r.req = req; r.vld = vld; r.sq = sq; r.err = err;
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; stall = 0; fetch_ack = 0; branch_taken = 0; branch_annul = 0; branch_target = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; fetch_ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({pc, npc, fetch_req, fetch_valid, squash, branch_err, fetch_count} !==
          {32'h0, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0})
        $display("FAIL reset_state got pc=%h npc=%h req=%b vld=%b sq=%b err=%b cnt=%0d want 0/4/0/0/0/0/0",
                 pc, npc, fetch_req, fetch_valid, squash, branch_err, fetch_count);
      else passed++;
    end
  endtask

  task automatic test_sequential();
    row_t rows[$];
    row_t e;
    do_reset();
    rows.push_back(mk(0,1,0,0,0, 32'h0, 32'h4,  0,0,0,0));
    rows.push_back(mk(0,1,0,0,0, 32'h0, 32'h4,  1,0,0,0));
    rows.push_back(mk(0,1,0,0,0, 32'h4, 32'h8,  1,1,0,0));
    rows.push_back(mk(0,1,0,0,0, 32'h8, 32'hC,  1,1,0,0));
    rows.push_back(mk(0,1,0,0,0, 32'hC, 32'h10, 1,1,0,0));
    foreach (rows[i]) begin
      stall = rows[i].st; fetch_ack = rows[i].ack; branch_taken = rows[i].br;
      branch_annul = rows[i].an; branch_target = rows[i].tgt;
      sb.push_back(rows[i]);
      #1;
      e = sb.pop_front();
      checks++;
      if ({pc, npc, fetch_req, fetch_valid, squash, branch_err} !== {e.pc, e.npc, e.req, e.vld, e.sq, e.err})
        $display("FAIL seq[%0d] got pc=%h npc=%h req=%b vld=%b sq=%b err=%b want pc=%h npc=%h req=%b vld=%b sq=%b err=%b",
                 i, pc, npc, fetch_req, fetch_valid, squash, branch_err, e.pc, e.npc, e.req, e.vld, e.sq, e.err);
      else passed++;
      if (i == 4) begin
        checks++;
        if (fetch_count !== 32'd3) $display("FAIL seq_count got %0d want 3", fetch_count);
        else passed++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wait();
    row_t rows[$];
    row_t e;
    do_reset();
    rows.push_back(mk(0,1,0,0,0, 32'h0, 32'h4,  0,0,0,0));
    rows.push_back(mk(0,1,0,0,0, 32'h0, 32'h4,  1,0,0,0));
    rows.push_back(mk(0,1,0,0,0, 32'h4, 32'h8,  1,1,0,0));
    rows.push_back(mk(0,0,0,0,0, 32'h8, 32'hC,  1,1,0,0));
    rows.push_back(mk(0,0,0,0,0, 32'h8, 32'hC,  1,0,0,0));
    rows.push_back(mk(0,0,0,0,0, 32'h8, 32'hC,  1,0,0,0));
    rows.push_back(mk(0,1,0,0,0, 32'h8, 32'hC,  1,0,0,0));
    rows.push_back(mk(0,1,0,0,0, 32'hC, 32'h10, 1,1,0,0));
    foreach (rows[i]) begin
      stall = rows[i].st; fetch_ack = rows[i].ack; branch_taken = rows[i].br;
      branch_annul = rows[i].an; branch_target = rows[i].tgt;
      sb.push_back(rows[i]);
      #1;
      e = sb.pop_front();
      checks++;
      if ({pc, npc, fetch_req, fetch_valid, squash, branch_err} !== {e.pc, e.npc, e.req, e.vld, e.sq, e.err})
        $display("FAIL wait[%0d] got pc=%h npc=%h req=%b vld=%b sq=%b err=%b want pc=%h npc=%h req=%b vld=%b sq=%b err=%b",
                 i, pc, npc, fetch_req, fetch_valid, squash, branch_err, e.pc, e.npc, e.req, e.vld, e.sq, e.err);
      else passed++;
      if (i == 7) begin
        checks++;
        if (fetch_count !== 32'd3) $display("FAIL wait_count got %0d want 3", fetch_count);
        else passed++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branch(input logic annul);
    row_t rows[$];
    row_t e;
    do_reset();
    rows.push_back(mk(0,1,0,0,0, 32'h0,   32'h4,   0,0,0,0));
    rows.push_back(mk(0,1,0,0,0, 32'h0,   32'h4,   1,0,0,0));
    rows.push_back(mk(0,1,0,0,0, 32'h4,   32'h8,   1,1,0,0));
    rows.push_back(mk(0,1,0,0,0, 32'h8,   32'hC,   1,1,0,0));
    rows.push_back(mk(0,1,0,0,0, 32'hC,   32'h10,  1,1,0,0));
    rows.push_back(mk(0,1,1,annul,32'h100, 32'h10, 32'h14, 1,1,0,0));
    rows.push_back(mk(0,1,0,0,0, 32'h14,  32'h100, 1,1,0,0));
    rows.push_back(mk(0,1,0,0,0, 32'h100, 32'h104, 1,1,annul,0));
    rows.push_back(mk(0,1,0,0,0, 32'h104, 32'h108, 1,1,0,0));
    foreach (rows[i]) begin
      stall = rows[i].st; fetch_ack = rows[i].ack; branch_taken = rows[i].br;
      branch_annul = rows[i].an; branch_target = rows[i].tgt;
      sb.push_back(rows[i]);
      #1;
      e = sb.pop_front();
      checks++;
      if ({pc, npc, fetch_req, fetch_valid, squash, branch_err} !== {e.pc, e.npc, e.req, e.vld, e.sq, e.err})
        $display("FAIL branch_an%0b[%0d] got pc=%h npc=%h req=%b vld=%b sq=%b err=%b want pc=%h npc=%h req=%b vld=%b sq=%b err=%b",
                 annul, i, pc, npc, fetch_req, fetch_valid, squash, branch_err, e.pc, e.npc, e.req, e.vld, e.sq, e.err);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_stall_branch();
    row_t rows[$];
    row_t e;
    do_reset();
    rows.push_back(mk(0,1,0,0,0, 32'h0,   32'h4,   0,0,0,0));
    rows.push_back(mk(0,1,0,0,0, 32'h0,   32'h4,   1,0,0,0));
    rows.push_back(mk(0,1,0,0,0, 32'h4,   32'h8,   1,1,0,0));
    rows.push_back(mk(0,1,0,0,0, 32'h8,   32'hC,   1,1,0,0));
    rows.push_back(mk(0,1,0,0,0, 32'hC,   32'h10,  1,1,0,0));
    rows.push_back(mk(1,1,1,0,32'h200, 32'h10, 32'h14, 0,1,0,0));
    rows.push_back(mk(1,1,1,1,32'h300, 32'h10, 32'h14, 0,0,0,0));
    rows.push_back(mk(0,1,0,0,0, 32'h10,  32'h14,  0,0,0,1));
    rows.push_back(mk(0,1,0,0,0, 32'h10,  32'h14,  1,0,0,1));
    rows.push_back(mk(0,1,0,0,0, 32'h14,  32'h200, 1,1,0,1));
    rows.push_back(mk(0,1,0,0,0, 32'h200, 32'h204, 1,1,0,1));
    foreach (rows[i]) begin
      stall = rows[i].st; fetch_ack = rows[i].ack; branch_taken = rows[i].br;
      branch_annul = rows[i].an; branch_target = rows[i].tgt;
      sb.push_back(rows[i]);
      #1;
      e = sb.pop_front();
      checks++;
      if ({pc, npc, fetch_req, fetch_valid, squash, branch_err} !== {e.pc, e.npc, e.req, e.vld, e.sq, e.err})
        $display("FAIL stall_br[%0d] got pc=%h npc=%h req=%b vld=%b sq=%b err=%b want pc=%h npc=%h req=%b vld=%b sq=%b err=%b",
                 i, pc, npc, fetch_req, fetch_valid, squash, branch_err, e.pc, e.npc, e.req, e.vld, e.sq, e.err);
      else passed++;
      if (i == 10) begin
        checks++;
        if (fetch_count !== 32'd6) $display("FAIL stall_count got %0d want 6", fetch_count);
        else passed++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    row_t rows[$];
    row_t e;
    do_reset();
    rows.push_back(mk(0,1,0,0,0, 32'h0, 32'h4, 0,0,0,0));
    rows.push_back(mk(0,1,1,0,32'hFFFF_FFF8, 32'h0, 32'h4, 1,0,0,0));
    rows.push_back(mk(0,1,0,0,0, 32'h4,         32'hFFFF_FFF8, 1,1,0,0));
    rows.push_back(mk(0,1,0,0,0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 1,1,0,0));
    rows.push_back(mk(0,1,0,0,0, 32'hFFFF_FFFC, 32'h0,         1,1,0,0));
    rows.push_back(mk(0,1,0,0,0, 32'h0,         32'h4,         1,1,0,0));
    foreach (rows[i]) begin
      stall = rows[i].st; fetch_ack = rows[i].ack; branch_taken = rows[i].br;
      branch_annul = rows[i].an; branch_target = rows[i].tgt;
      sb.push_back(rows[i]);
      #1;
      e = sb.pop_front();
      checks++;
      if ({pc, npc, fetch_req, fetch_valid, squash, branch_err} !== {e.pc, e.npc, e.req, e.vld, e.sq, e.err})
        $display("FAIL wrap[%0d] got pc=%h npc=%h req=%b vld=%b sq=%b err=%b want pc=%h npc=%h req=%b vld=%b sq=%b err=%b",
                 i, pc, npc, fetch_req, fetch_valid, squash, branch_err, e.pc, e.npc, e.req, e.vld, e.sq, e.err);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    row_t pre[$];
    row_t post[$];
    row_t e;
    do_reset();
    pre.push_back(mk(0,1,0,0,0,        32'h0, 32'h4, 0,0,0,0));
    pre.push_back(mk(0,1,0,0,0,        32'h0, 32'h4, 1,0,0,0));
    pre.push_back(mk(0,0,0,0,0,        32'h4, 32'h8, 1,1,0,0));
    pre.push_back(mk(0,0,1,1,32'h500,  32'h4, 32'h8, 1,0,0,0));
    pre.push_back(mk(0,0,0,0,0,        32'h4, 32'h8, 1,0,0,0));
    foreach (pre[i]) begin
      stall = pre[i].st; fetch_ack = pre[i].ack; branch_taken = pre[i].br;
      branch_annul = pre[i].an; branch_target = pre[i].tgt;
      sb.push_back(pre[i]);
      #1;
      e = sb.pop_front();
      checks++;
      if ({pc, npc, fetch_req, fetch_valid, squash, branch_err} !== {e.pc, e.npc, e.req, e.vld, e.sq, e.err})
        $display("FAIL arst_pre[%0d] got pc=%h npc=%h req=%b vld=%b sq=%b err=%b want pc=%h npc=%h req=%b vld=%b sq=%b err=%b",
                 i, pc, npc, fetch_req, fetch_valid, squash, branch_err, e.pc, e.npc, e.req, e.vld, e.sq, e.err);
      else passed++;
      if (i < 4) @(negedge clk);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({pc, npc, fetch_req, fetch_valid, fetch_count} !== {32'h0, 32'h4, 1'b0, 1'b0, 32'h0})
      $display("FAIL arst_immediate got pc=%h npc=%h req=%b vld=%b cnt=%0d want 0/4/0/0/0",
               pc, npc, fetch_req, fetch_valid, fetch_count);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    post.push_back(mk(0,1,0,0,0, 32'h0, 32'h4, 0,0,0,0));
    post.push_back(mk(0,1,0,0,0, 32'h0, 32'h4, 1,0,0,0));
    post.push_back(mk(0,1,0,0,0, 32'h4, 32'h8, 1,1,0,0));
    post.push_back(mk(0,1,0,0,0, 32'h8, 32'hC, 1,1,0,0));
    foreach (post[i]) begin
      stall = post[i].st; fetch_ack = post[i].ack; branch_taken = post[i].br;
      branch_annul = post[i].an; branch_target = post[i].tgt;
      sb.push_back(post[i]);
      #1;
      e = sb.pop_front();
      checks++;
      if ({pc, npc, fetch_req, fetch_valid, squash, branch_err} !== {e.pc, e.npc, e.req, e.vld, e.sq, e.err})
        $display("FAIL arst_post[%0d] got pc=%h npc=%h req=%b vld=%b sq=%b err=%b want pc=%h npc=%h req=%b vld=%b sq=%b err=%b",
                 i, pc, npc, fetch_req, fetch_valid, squash, branch_err, e.pc, e.npc, e.req, e.vld, e.sq, e.err);
      else passed++;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wait();
    test_branch(1'b0);
    test_branch(1'b1);
    test_stall_branch();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
